edge_conv3x3_stream: RTL
========================

// Module: edge_conv3x3_stream
// PURPOSE
//  Streaming 3x3 edge-detection engine; successor to the fixed-size Sobel filter.
//  - Frame size is set at run time, up to MAX_IMG_W x MAX_IMG_H.
//  - Kernel mode is selectable.
//  - Valid/ready handshakes on both input and output.
//  - Sits between the pixel source (PGM loader / DMA) and the frame writer.
//  - Emits only interior pixels: (W-2)x(H-2) per frame, raster order.
// PARAMETERS
//  WIDTH      8    pixel bit width (unsigned)
//  MAX_IMG_W  512  max frame width; sets line-buffer depth
//  MAX_IMG_H  512  max frame height
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  start      in   1       1-cycle pulse; latches img_w/img_h/mode when IDLE
//  img_w      in   DW      frame width; DW = $clog2(MAX_IMG_W+1)
//  img_h      in   DH      frame height; DH = $clog2(MAX_IMG_H+1)
//  mode       in   2       0 Sobel |Gx|+|Gy|; 1 Sobel |Gx|; 2 Sobel |Gy|; 3 Laplacian-4
//  threshold  in   WIDTH   binarise level (present only with EDGE_THRESH_EN)
//  in_valid   in   1       pixel_in valid
//  in_ready   out  1       engine accepts pixel_in this cycle
//  pixel_in   in   WIDTH   raster-order input pixel
//  out_valid  out  1       pixel_out valid
//  out_ready  in   1       sink accepts pixel_out
//  pixel_out  out  WIDTH   filtered interior pixel
//  out_last   out  1       marks last interior pixel of frame (qualified by out_valid)
//  busy       out  1       high in RUN or DRAIN
//  done       out  1       1-cycle pulse at end of frame
//  err        out  1       1-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset:
//  - All outputs are 0.
//  - FSM goes to IDLE; row/column counters clear; line buffers are not cleared.
//  - rst mid-frame aborts immediately; no done pulse; the next start begins a fresh frame.
//  FSM IDLE -> RUN -> DRAIN -> IDLE:
//  - IDLE:
//    - start with 3<=img_w<=MAX_IMG_W and 3<=img_h<=MAX_IMG_H: latch config, go to RUN.
//    - start with illegal size: err=1 for one cycle, stay in IDLE.
//  - RUN:
//    - in_ready = !out_valid || out_ready (one-deep output register).
//    - Input handshake = in_valid && in_ready; col/row counters advance only on it.
//    - start is ignored in RUN and DRAIN.
//    - After accepting pixel (row h-1, col w-1): go to DRAIN, in_ready=0.
//  - DRAIN:
//    - Wait until the output register is empty or being accepted.
//    - Then done=1 for one cycle and return to IDLE.
//  Windowing and latency:
//  - Two line buffers of MAX_IMG_W x WIDTH, plus a 3x3 shift window.
//  - Accepting pixel (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1).
//  - The result is registered: out_valid rises the next cycle (latency 1).
//  - Output holds stable while out_valid && !out_ready.
//  - Column wrap: window columns reset at c=0; no outputs for c<2 or r<2.
//  Arithmetic:
//  - Gx, Gy signed WIDTH+3 bits, standard Sobel kernels.
//  - Laplacian L = 4*C - N - S - E - W, signed WIDTH+3 bits.
//  - Result is the absolute value (sum for mode 0), saturated to 2^WIDTH-1. No wrap.
//  - Simultaneous out_ready and a new result: the register reloads that cycle; no bubble.
// CONFIGURATION
//  EDGE_THRESH_EN defined:
//  - threshold port exists.
//  - pixel_out = (result >= threshold) ? 2^WIDTH-1 : 0.
//  - threshold is latched at start.
//  EDGE_THRESH_EN undefined:
//  - threshold port absent; pixel_out is the saturated magnitude.
// STRUCTURE
//  Package edge_conv_pkg:
//  - mode enum: MODE_SOBEL_MAG, MODE_SOBEL_X, MODE_SOBEL_Y, MODE_LAPLACE.
//  - FSM state enum.
//  - Kernel coefficient constants.
//  - Function sat_abs(signed value, WIDTH).
//  Sub-module edge_line_buffer:
//  - Two-row circular buffer, write/read at the column index, enable = input handshake.
//  - Returns the column of rows r-2 and r-1.
// TESTING
//  - Ramp / flat:
//    - 5x5 frame, pixel = 10*col, mode 0, out_ready=1 -> 9 outputs, each 80.
//    - Constant-100 image -> all 0.
//  - Step edge and saturation:
//    - 6x4 frame, cols 0-2 = 0, cols 3-5 = 255, mode 1 -> row outputs 0,255,255,0 (saturated).
//    - Same frame, mode 2 -> all 0.
//  - Laplacian:
//    - 3x3 frame, centre 50, others 0, mode 3 -> single output 200.
//    - out_last=1 with it; done pulses after acceptance.
//  - Backpressure:
//    - Random in_valid, out_ready toggled 1-in-3 on a 16x8 frame.
//    - Check: 84 outputs matching the software model.
//    - Check: no drops or duplicates; pixel_out stable while stalled.
//  - Bad config:
//    - start with img_w=2 -> err pulse, busy stays 0.
//    - start during RUN -> ignored, frame completes normally.
//  - Reset mid-frame:
//    - rst at pixel 20 of a 8x8 frame -> all outputs 0 next cycle.
//    - A following 5x5 frame produces exactly 9 correct outputs.
//  - EDGE_THRESH_EN build:
//    - step-edge frame, threshold=128 -> outputs 0,255,255,0.
//    - Non-threshold build of the same frame -> 0,255,255,0 as magnitudes.

Source files
------------

// File: rtl/edge_conv_pkg.sv
// edge_conv_pkg: shared types, kernel weights and saturation helper for edge_conv3x3_stream
package edge_conv_pkg;
  typedef enum logic [1:0] {MODE_SOBEL_MAG, MODE_SOBEL_X, MODE_SOBEL_Y, MODE_LAPLACE} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
  localparam int K_SIDE = 1;
  localparam int K_CENTRE = 2;
  localparam int K_LAP = 4;
  function automatic int sat_abs(input int v, input int w);
    int a;
    a = v < 0 ? -v : v;
    return a > (1 << w) - 1 ? (1 << w) - 1 : a;
  endfunction
endpackage

// File: rtl/edge_line_buffer.sv
// edge_line_buffer: two-row circular line store feeding the 3x3 window
// Ports: clk; i_en write strobe (input handshake); i_sel row parity (row[0]);
//        i_addr column; i_pix incoming pixel; o_top row r-2 and o_mid row r-1 at i_addr.
module edge_line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_sel,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_pix,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_mid
);
  logic [WIDTH-1:0] r_b0 [DEPTH];
  logic [WIDTH-1:0] r_b1 [DEPTH];
  // bank row[0] holds row r-2 and is overwritten by row r; the other bank holds row r-1
  assign o_top = i_sel ? r_b1[i_addr] : r_b0[i_addr];
  assign o_mid = i_sel ? r_b0[i_addr] : r_b1[i_addr];
  always_ff @(posedge clk) if (i_en && !i_sel) r_b0[i_addr] <= i_pix;
  always_ff @(posedge clk) if (i_en && i_sel) r_b1[i_addr] <= i_pix;
endmodule

// File: rtl/edge_conv3x3_stream.sv
// edge_conv3x3_stream: streaming 3x3 Sobel/Laplacian edge engine emitting interior pixels
// Ports: clk, rst (sync, active-high); start/img_w/img_h/mode frame config;
//        in_valid/in_ready/pixel_in input stream; out_valid/out_ready/pixel_out/out_last
//        output stream; busy, done, err status. EDGE_THRESH_EN adds a threshold input
//        and binarises pixel_out.
module edge_conv3x3_stream
  import edge_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_IMG_W = 512,
  parameter int MAX_IMG_H = 512,
  localparam int DW = $clog2(MAX_IMG_W + 1),
  localparam int DH = $clog2(MAX_IMG_H + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    img_w,
  input  logic [DH-1:0]    img_h,
  input  logic [1:0]       mode,
`ifdef EDGE_THRESH_EN
  input  logic [WIDTH-1:0] threshold,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pixel_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pixel_out,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int AW = $clog2(MAX_IMG_W);
  localparam int SW = WIDTH + 3;
  state_e r_state, w_next;
  mode_e r_mode;
  logic [DW-1:0] r_w, r_col;
  logic [DH-1:0] r_h, r_row;
  logic [WIDTH-1:0] r_l [3];
  logic [WIDTH-1:0] r_m [3];
  logic [WIDTH-1:0] w_top, w_mid, w_res, w_out;
  logic w_go, w_legal, w_acc, w_eol, w_end, w_emit;
  logic signed [SW-1:0] w_gx, w_gy, w_lap;
  int w_a [3][3];
  int w_mag;
  assign w_legal = img_w >= DW'(3) && img_w <= DW'(MAX_IMG_W) && img_h >= DH'(3) && img_h <= DH'(MAX_IMG_H);
  assign w_go = r_state == S_IDLE && start && w_legal;
  assign in_ready = r_state == S_RUN && (!out_valid || out_ready);
  assign w_acc = in_valid && in_ready;
  assign w_eol = r_col == r_w - DW'(1);
  assign w_end = w_eol && r_row == r_h - DH'(1);
  assign w_emit = w_acc && r_row >= DH'(2) && r_col >= DW'(2);
  assign busy = r_state != S_IDLE;
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    err = r_state == S_IDLE && start && !w_legal;
    done = r_state == S_DRAIN && (!out_valid || out_ready);
    w_next = w_go ? S_RUN : r_state == S_RUN && w_acc && w_end ? S_DRAIN : done ? S_IDLE : r_state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_w <= '0;
      r_h <= '0;
      r_mode <= MODE_SOBEL_MAG;
    end else if (w_go) begin
      r_col <= '0;
      r_row <= '0;
      r_w <= img_w;
      r_h <= img_h;
      r_mode <= mode_e'(mode);
    end else if (w_acc) begin
      r_col <= w_eol ? '0 : r_col + DW'(1);
      r_row <= w_eol ? r_row + DH'(1) : r_row;
    end
  edge_line_buffer #(.WIDTH(WIDTH), .DEPTH(MAX_IMG_W)) u_lb (
    .clk(clk), .i_en(w_acc), .i_sel(r_row[0]), .i_addr(r_col[AW-1:0]),
    .i_pix(pixel_in), .o_top(w_top), .o_mid(w_mid)
  );
  // window columns left/middle; the right column is the line-buffer read plus pixel_in
  always_ff @(posedge clk)
    if (w_acc) begin
      r_l <= r_m;
      r_m <= '{w_top, w_mid, pixel_in};
    end
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_a[i][0] = int'(r_l[i]);
      w_a[i][1] = int'(r_m[i]);
    end
    w_a[0][2] = int'(w_top);
    w_a[1][2] = int'(w_mid);
    w_a[2][2] = int'(pixel_in);
    w_gx = SW'(K_SIDE * (w_a[0][2] - w_a[0][0]) + K_CENTRE * (w_a[1][2] - w_a[1][0]) + K_SIDE * (w_a[2][2] - w_a[2][0]));
    w_gy = SW'(K_SIDE * (w_a[2][0] - w_a[0][0]) + K_CENTRE * (w_a[2][1] - w_a[0][1]) + K_SIDE * (w_a[2][2] - w_a[0][2]));
    w_lap = SW'(K_LAP * w_a[1][1] - w_a[0][1] - w_a[2][1] - w_a[1][0] - w_a[1][2]);
    w_mag = r_mode == MODE_SOBEL_X ? sat_abs(int'(w_gx), WIDTH) :
            r_mode == MODE_SOBEL_Y ? sat_abs(int'(w_gy), WIDTH) :
            r_mode == MODE_LAPLACE ? sat_abs(int'(w_lap), WIDTH) :
            sat_abs(sat_abs(int'(w_gx), SW) + sat_abs(int'(w_gy), SW), WIDTH);
    w_res = WIDTH'(w_mag);
  end
`ifdef EDGE_THRESH_EN
  logic [WIDTH-1:0] r_thr;
  always_ff @(posedge clk) r_thr <= rst ? '0 : w_go ? threshold : r_thr;
  assign w_out = w_res >= r_thr ? '1 : '0;
`else
  assign w_out = w_res;
`endif
  // one-deep output register: a new result may load in the same cycle the old one is taken
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
      out_last <= 1'b0;
    end else if (w_emit) begin
      out_valid <= 1'b1;
      pixel_out <= w_out;
      out_last <= w_end;
    end else if (out_ready) out_valid <= 1'b0;
endmodule
